captura_adc: RTL and testbench

Downstream capture stage for the ADC conversion controller. Samples the 8-bit ADC data bus once per controller `oe` pulse and accumulates 2^LOG2N consecutive samples. It then presents their truncated mean to the consumer through a valid/ready handshake. An `overrun` flag is set if a new mean completes while the previous one has not been accepted.

---
 rtl/captura_adc.sv | 78 +++++++
 tb/tb_captura_adc.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/captura_adc.sv
// ADC capture stage: takes one sample per rising edge of oe, averages blocks of
// 2^LOG2N samples and hands the truncated mean to a valid/ready consumer.
module captura_adc #(
    parameter int WIDTH = 8,
    parameter int LOG2N = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             oe,
    input  logic [WIDTH-1:0] dato,
    input  logic             ready,
    output logic [WIDTH-1:0] promedio,
    output logic             valid,
    output logic             overrun,
    output logic [LOG2N-1:0] cuenta
);

    localparam int AW = WIDTH + LOG2N;

    typedef enum logic {VACIO, LLENO} estado_t;

    estado_t         estado, estado_sig;
    logic            oe_q;
    logic            captura, completa, carga, descarte;
    logic [AW-1:0]   acc, suma;

    // One capture per oe pulse; oe_q resets low so oe already high at release counts.
    assign captura  = oe & ~oe_q;
    assign completa = captura && (cuenta == '1);
    assign suma     = acc + AW'(dato);

    // Output-register FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) estado <= VACIO;
        else        estado <= estado_sig;
    end

    // Output-register FSM: next state
    always_comb begin
        estado_sig = estado;
        case (estado)
            VACIO:   if (completa) estado_sig = LLENO;
            LLENO:   if (ready && !completa) estado_sig = VACIO;
            default: estado_sig = VACIO;
        endcase
    end

    // Output-register FSM: outputs and load/drop decisions
    always_comb begin
        valid    = (estado == LLENO);
        carga    = completa && ((estado == VACIO) || ready);
        descarte = completa && (estado == LLENO) && !ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oe_q     <= 1'b0;
            acc      <= '0;
            cuenta   <= '0;
            promedio <= '0;
            overrun  <= 1'b0;
        end else begin
            oe_q <= oe;
            if (captura) begin
                if (completa) begin
                    acc    <= '0;
                    cuenta <= '0;
                end else begin
                    acc    <= suma;
                    cuenta <= cuenta + LOG2N'(1);
                end
            end
            if (carga)    promedio <= suma[AW-1:LOG2N];
            if (descarte) overrun  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_captura_adc.sv
// Directed bench for captura_adc: accepted results go through a scoreboard queue
// checked by a monitor on every valid/ready transfer; status outputs are checked inline.
module tb_captura_adc;

    logic       clk = 1'b0;
    logic       reset, oe, ready;
    logic [7:0] dato, promedio;
    logic       valid, overrun;
    logic [1:0] cuenta;

    int checks = 0;
    int errors = 0;
    int q[$];

    captura_adc #(.WIDTH(8), .LOG2N(2)) dut (
        .clk(clk), .reset(reset), .oe(oe), .dato(dato), .ready(ready),
        .promedio(promedio), .valid(valid), .overrun(overrun), .cuenta(cuenta)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge whenever valid && ready mid-cycle.
    always @(negedge clk) begin
        if (reset === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL transfer: got %0d expected none (queue empty)", promedio);
            end else begin
                chk("transfer", promedio, q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // Entered and left at posedge+1; oe high across one edge, then low across one edge.
    task automatic pulse(input logic [7:0] d, input logic rdy = 1'b0);
        oe = 1'b1; dato = d; ready = rdy;
        @(posedge clk); #1;
        oe = 1'b0; ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic block4(input logic [7:0] d);
        repeat (4) pulse(d);
    endtask

    task automatic ack();
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; oe = 1'b0; ready = 1'b0; dato = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst promedio", promedio, 0);
        chk("rst valid", valid, 0);
        chk("rst overrun", overrun, 0);
        chk("rst cuenta", cuenta, 0);
        reset = 1'b1;

        // Basic block: 10,20,30,40 -> 25
        pulse(10); chk("cuenta1", cuenta, 1);
        pulse(20); chk("cuenta2", cuenta, 2);
        pulse(30); chk("cuenta3", cuenta, 3);
        q.push_back(25);
        oe = 1'b1; dato = 40;
        @(posedge clk); #1;
        chk("valid on 4th edge", valid, 1);
        chk("promedio on 4th edge", promedio, 25);
        chk("cuenta wrap", cuenta, 0);
        oe = 1'b0;
        @(posedge clk); #1;
        ack();
        chk("valid after ack", valid, 0);
        chk("promedio held", promedio, 25);

        // Full scale and truncation
        q.push_back(255);
        block4(255);
        chk("max promedio", promedio, 255);
        ack();
        q.push_back(1);
        pulse(1); pulse(1); pulse(1); pulse(2);
        chk("trunc promedio", promedio, 1);
        ack();

        // Long oe pulse gives one capture
        oe = 1'b1; dato = 5;
        @(posedge clk); #1 dato = 6;
        @(posedge clk); #1 dato = 7;
        @(posedge clk); #1 oe = 1'b0;
        @(posedge clk); #1;
        chk("long pulse cuenta", cuenta, 1);
        q.push_back(5);
        pulse(5); pulse(5); pulse(5);
        chk("long pulse promedio", promedio, 5);
        ack();

        // Overrun: block 2 completes while block 1 still unaccepted
        q.push_back(12);
        block4(12);
        block4(40);
        chk("overrun set", overrun, 1);
        chk("overrun valid", valid, 1);
        chk("overrun promedio kept", promedio, 12);
        ack();
        chk("overrun sticky", overrun, 1);
        do_reset();
        chk("overrun cleared", overrun, 0);

        // Ack on the completion edge: new mean loads, valid stays, no overrun
        q.push_back(60);
        block4(60);
        q.push_back(80);
        pulse(80); pulse(80); pulse(80); pulse(80, 1'b1);
        chk("ack+compl promedio", promedio, 80);
        chk("ack+compl valid", valid, 1);
        chk("ack+compl overrun", overrun, 0);
        ack();
        chk("ack+compl drained", valid, 0);

        // Async reset mid-cycle discards partial and pending results
        block4(100);
        chk("pre-reset promedio", promedio, 100);
        pulse(100); pulse(100);
        chk("pre-reset cuenta", cuenta, 2);
        #2 reset = 1'b0;
        #1;
        chk("async promedio", promedio, 0);
        chk("async valid", valid, 0);
        chk("async cuenta", cuenta, 0);
        chk("async overrun", overrun, 0);
        @(posedge clk); #1 reset = 1'b1;
        q.push_back(8);
        block4(8);
        chk("post-reset promedio", promedio, 8);
        ack();

        // oe high across reset release: first edge is a capture
        reset = 1'b0; oe = 1'b1; dato = 9;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("oe at release cuenta", cuenta, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("oe held no recapture", cuenta, 1);
        oe = 1'b0;
        @(posedge clk); #1;

        chk("scoreboard drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
